pc_fetch_stage: RTL
===================

PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 Parameter WIDTH, default 32, shall set the address/instruction data width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, shall set the PC value loaded on reset.
REQ-003 clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  shall be a synchronous, active-low reset.
REQ-005 next_pc  input  WIDTH  shall be the next-PC candidate produced by the next-PC selection logic.
REQ-006 pc_load  input  1  shall request loading next_pc into the PC this cycle.
REQ-007 curr_pc  output  WIDTH  shall be the registered PC, fed back to next-PC selection.
REQ-008 imem_req  output  1  shall request an instruction read.
REQ-009 imem_addr  output  WIDTH  shall be the read address, always equal to curr_pc.
REQ-010 imem_gnt  input  1  shall signal that memory accepts the request this cycle.
REQ-011 imem_rvalid  input  1  shall signal that imem_rdata is valid this cycle.
REQ-012 imem_rdata  input  WIDTH  shall be the returned instruction word.
REQ-013 instr_valid  output  1  shall signal that instr and instr_pc are valid for decode.
REQ-014 instr_ready  input  1  shall signal that decode accepts the instruction.
REQ-015 instr  output  WIDTH  shall be the registered instruction word.
REQ-016 instr_pc  output  WIDTH  shall be the PC of the instruction on instr.
REQ-017 fault  output  1  shall flag a misaligned PC load; sticky until reset.

Function
REQ-018 FSM states shall be REQ, RSP, HOLD, WAIT_PC, DROP, FAULT.
REQ-019 REQ: imem_req=1; on imem_gnt -> RSP.
REQ-020 RSP: imem_req=0; on imem_rvalid, instr<=imem_rdata, instr_pc<=curr_pc -> HOLD.
REQ-021 HOLD: instr_valid=1; on instr_ready -> WAIT_PC; instr/instr_pc shall stay stable while instr_valid=1 and instr_ready=0.
REQ-022 WAIT_PC: on pc_load, curr_pc<=next_pc -> REQ.
REQ-023 At most one memory request outstanding; response latency >=1 cycle after grant, unbounded.
REQ-024 pc_load in REQ: curr_pc<=next_pc, stay REQ, request reissued at new address next cycle; the gnt in that same cycle is treated as belonging to the old address -> DROP.
REQ-025 pc_load in RSP: curr_pc<=next_pc -> DROP; a same-cycle imem_rvalid is discarded.
REQ-026 DROP: imem_req=0; on imem_rvalid discard data -> REQ.
REQ-027 pc_load in HOLD: instruction flushed, curr_pc<=next_pc, instr_valid=0 next cycle -> REQ, even if instr_ready=1 that cycle (handshake cancelled).
REQ-028 pc_load with next_pc[1:0]!=0 in any state: curr_pc unchanged, fault<=1 -> FAULT.
REQ-029 FAULT: imem_req=0, instr_valid=0; left only by reset; imem_rvalid ignored.
REQ-030 imem_rvalid in REQ, HOLD, WAIT_PC shall be ignored.
REQ-031 curr_pc update shall be a plain WIDTH-bit load, no arithmetic inside this block.

Reset
REQ-032 rst_n=0 at a clock edge: state<=REQ, curr_pc<=RESET_PC, instr<=0, instr_pc<=0, fault<=0.
REQ-033 Outputs during and one cycle after reset: instr_valid=0; imem_req=1 from the first cycle with rst_n=1.
REQ-034 Reset mid-transaction shall abandon any outstanding request; a later stale imem_rvalid shall be discarded only if it arrives in DROP, so the memory side shall also be reset.

Structure
REQ-035 The state enum (fetch_state_t) and RESET_PC default shall reside in the shared processor package.
REQ-036 No sub-module is required; the FSM and registers shall be in one module.

Verification
REQ-037 Reset, gnt=1, rvalid 2 cycles later with 32'h00500093, instr_ready=1: instr_valid for exactly 1 cycle, instr_pc=0.
REQ-038 instr_ready held 0 for 5 cycles in HOLD: instr and instr_pc stable, no new imem_req.
REQ-039 pc_load next_pc=32'h40 while in RSP, then rvalid with 32'hDEADBEEF: data discarded, next imem_addr=32'h40, instr_valid never shows DEADBEEF.
REQ-040 pc_load next_pc=32'h42 in WAIT_PC: fault=1, curr_pc unchanged, imem_req=0 until reset.
REQ-041 rst_n=0 for one cycle while in RSP: curr_pc=RESET_PC, imem_req=1 next cycle, instr_valid=0.
REQ-042 pc_load and instr_ready both 1 in HOLD with next_pc=32'h100: instruction flushed, next fetch from 32'h100.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared processor package: fetch FSM states and reset vector.
// Imported by the fetch stage and anything that decodes its state.
package pc_fetch_pkg;

  typedef enum logic [2:0] {
    S_REQ,
    S_RSP,
    S_HOLD,
    S_WAIT_PC,
    S_DROP,
    S_FAULT
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_stage.sv
// PC register and single-outstanding instruction fetch FSM.
// Presents one fetched word at a time to decode.
module pc_fetch_stage
  import pc_fetch_pkg::*;
#(
  parameter int              WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] next_pc,
  input  logic             pc_load,
  output logic [WIDTH-1:0] curr_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             fault
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] ipc_q, ipc_d;
  logic             fault_q, fault_d;
  logic             load_ok;
  logic             load_bad;

  assign load_bad = pc_load && misaligned(next_pc[1:0]);
  assign load_ok  = pc_load && !load_bad;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    fault_d = fault_q;
    unique case (state_q)
      S_REQ: begin
        // A grant in the redirect cycle belongs to the old address.
        if (load_ok) begin
          pc_d = next_pc;
          if (imem_gnt) state_d = S_DROP;
        end else if (imem_gnt) begin
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        // If the response lands with the redirect, it is consumed here.
        if (load_ok) begin
          pc_d    = next_pc;
          state_d = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (load_ok) begin
          pc_d    = next_pc;
          state_d = S_REQ;
        end else if (instr_ready) begin
          state_d = S_WAIT_PC;
        end
      end
      S_WAIT_PC: begin
        if (load_ok) begin
          pc_d    = next_pc;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (load_ok) pc_d = next_pc;
        if (imem_rvalid) state_d = S_REQ;
      end
      S_FAULT: ;
      default: state_d = S_REQ;
    endcase
    if (load_bad && state_q != S_FAULT) begin
      pc_d    = pc_q;
      fault_d = 1'b1;
      state_d = S_FAULT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      fault_q <= fault_d;
    end
  end

  assign curr_pc     = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == S_REQ);
  assign instr_valid = (state_q == S_HOLD);
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign fault       = fault_q;

endmodule
